// File: rtl/mathbox_pkg.sv
// mathbox_pkg
//   Shared definitions for the mathbox sequencer: the controller state
//   encoding, the default run-length limit and the PC / EDB bus widths.
package mathbox_pkg;

  localparam int PC_W            = 8;
  localparam int EDB_W           = 8;
  localparam int MAX_RUN_DEFAULT = 255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mathbox_rd_port.sv
// mathbox_rd_port
//   CPU read port of the mathbox. A read strobe opens a one-cycle output
//   enable window on the ALU result nibbles (active low). At the close of
//   that window the ALU result byte is captured and a valid pulse issued.
// Ports:
//   clk        system clock
//   srst       synchronous active-high reset
//   rd_lo      accepted low-nibble read strobe (one cycle)
//   rd_hi      accepted high-nibble read strobe (one cycle)
//   alu_edb    result byte returned by the ALU datapath
//   ylo, yhi   active-low nibble output enables (registered)
//   cpu_dout   captured result byte
//   dout_valid one-cycle pulse marking a new cpu_dout
module mathbox_rd_port
  import mathbox_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             rd_lo,
  input  logic             rd_hi,
  input  logic [EDB_W-1:0] alu_edb,
  output logic             ylo,
  output logic             yhi,
  output logic [EDB_W-1:0] cpu_dout,
  output logic             dout_valid
);

  logic             ylo_reg;
  logic             yhi_reg;
  logic [EDB_W-1:0] cpu_dout_reg;
  logic             dout_valid_reg;
  logic             capture;

  // An enable window is open this cycle; the ALU drives its result now,
  // so the byte is taken on the edge that closes the window.
  assign capture = ~ylo_reg | ~yhi_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      ylo_reg        <= 1'b1;
      yhi_reg        <= 1'b1;
      cpu_dout_reg   <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      ylo_reg        <= ~rd_lo;
      yhi_reg        <= ~rd_hi;
      dout_valid_reg <= capture;
      if (capture) begin
        cpu_dout_reg <= alu_edb;
      end
    end
  end

  assign ylo        = ylo_reg;
  assign yhi        = yhi_reg;
  assign cpu_dout   = cpu_dout_reg;
  assign dout_valid = dout_valid_reg;

endmodule

// File: rtl/mathbox_ctrl.sv
// mathbox_ctrl
//   Microprogram sequencer for the mathbox. A CPU write loads the operand
//   byte, fetches a start address and runs microcode until the ROM stop
//   flag is seen or the run-length limit expires. Reads are served by
//   mathbox_rd_port independently of the sequencer.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   CPU_A         write-register select (indexes the start-address ROM)
//   CPU_DIN       CPU write data (operand byte)
//   MB_WR         write strobe, starts or restarts a run
//   MB_RD_LO/HI   read strobes for the result nibbles
//   START_PC      microcode start address from the start-address ROM
//   STOP_BIT      microcode stop flag at the current PC
//   ALU_EDB       result byte from the ALU datapath
//   EDB           operand byte to the ALU
//   PC            microcode ROM address
//   ALU_EN        ALU / register-file clock enable
//   YLO, YHI      active-low nibble output enables
//   CPU_DOUT      captured result byte, DOUT_VALID pulses on update
//   BUSY          a microprogram is running
//   TIMEOUT       sticky: last run hit the run-length limit
module mathbox_ctrl
  import mathbox_pkg::*;
#(
  parameter int MAX_RUN = MAX_RUN_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       CPU_A,
  input  logic [7:0]       CPU_DIN,
  input  logic             MB_WR,
  input  logic             MB_RD_LO,
  input  logic             MB_RD_HI,
  input  logic [PC_W-1:0]  START_PC,
  input  logic             STOP_BIT,
  input  logic [EDB_W-1:0] ALU_EDB,
  output logic [EDB_W-1:0] EDB,
  output logic [PC_W-1:0]  PC,
  output logic             ALU_EN,
  output logic             YLO,
  output logic             YHI,
  output logic [EDB_W-1:0] CPU_DOUT,
  output logic             DOUT_VALID,
  output logic             BUSY,
  output logic             TIMEOUT
);

  localparam int CNT_W = $clog2(MAX_RUN + 1);

  state_t           state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [EDB_W-1:0] edb_reg, edb_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0] run_cnt_inc;
  logic             timeout_reg, timeout_next;

  // CPU_A only selects the start-address ROM entry outside this block.
  logic             unused_cpu_a;
  assign unused_cpu_a = ^CPU_A;

  assign run_cnt_inc = run_cnt_reg + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      edb_reg     <= '0;
      run_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      edb_reg     <= edb_next;
      run_cnt_reg <= run_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    edb_next     = edb_reg;
    run_cnt_next = run_cnt_reg;
    timeout_next = timeout_reg;

    if (MB_WR) begin
      // A write always (re)starts a run; any stop flag this cycle belongs
      // to the abandoned program and is ignored.
      edb_next     = CPU_DIN;
      pc_next      = START_PC;
      run_cnt_next = '0;
      timeout_next = 1'b0;
      state_next   = ST_RUN;
    end else if (state_reg == ST_RUN) begin
      run_cnt_next = run_cnt_inc;
      if (STOP_BIT) begin
        // Stop instruction executes this cycle; PC stays on it.
        state_next = ST_IDLE;
      end else begin
        // Natural 8-bit wrap from FF to 00.
        pc_next = pc_reg + 1'b1;
        if (run_cnt_inc == CNT_W'(MAX_RUN)) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
        end
      end
    end
  end

  assign EDB     = edb_reg;
  assign PC      = pc_reg;
  assign BUSY    = (state_reg == ST_RUN);
  assign ALU_EN  = (state_reg == ST_RUN);
  assign TIMEOUT = timeout_reg;

  // A coincident write wins: the read strobe is discarded.
  logic rd_lo_acc;
  logic rd_hi_acc;
  assign rd_lo_acc = MB_RD_LO & ~MB_WR;
  assign rd_hi_acc = MB_RD_HI & ~MB_WR;

  mathbox_rd_port u_rd_port (
    .clk        (CLK),
    .srst       (RST),
    .rd_lo      (rd_lo_acc),
    .rd_hi      (rd_hi_acc),
    .alu_edb    (ALU_EDB),
    .ylo        (YLO),
    .yhi        (YHI),
    .cpu_dout   (CPU_DOUT),
    .dout_valid (DOUT_VALID)
  );

endmodule

// File: doc/mathbox_ctrl.md
MATHBOX_CTRL -- requirements
Module: mathbox_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning):
  CLK  in  1  system clock; all state changes on rising edge.
  RST  in  1  synchronous, active-high reset.
  CPU_A  in  5  CPU write-register select, sampled with MB_WR.
  CPU_DIN  in  8  CPU write data.
  MB_WR  in  1  one-cycle write strobe.
  MB_RD_LO  in  1  one-cycle read strobe, low result nibble.
  MB_RD_HI  in  1  one-cycle read strobe, high result nibble.
  START_PC  in  8  microcode start address from the start-address ROM, indexed by CPU_A.
  STOP_BIT  in  1  microcode stop flag at the current PC.
  ALU_EDB  in  8  EDB_OUT returned from the ALU datapath.
  EDB  out  8  operand byte driven onto the ALU EDB_IN.
  PC  out  8  microcode ROM address.
  ALU_EN  out  1  ALU/register-file clock enable.
  YLO  out  1  active-low lower-nibble output enable.
  YHI  out  1  active-low upper-nibble output enable.
  CPU_DOUT  out  8  captured result byte.
  DOUT_VALID  out  1  one-cycle pulse; CPU_DOUT updated.
  BUSY  out  1  status: a microprogram is running.
  TIMEOUT  out  1  sticky: the last run was force-stopped.
REQ-002 SHALL use one clock, CLK; reset RST SHALL be synchronous and active-high.
REQ-003 SHALL take one parameter, MAX_RUN = 255, the run-length limit in cycles.

Function
REQ-004 SHALL implement states IDLE and RUN; BUSY SHALL equal (state==RUN).
REQ-005 On MB_WR in IDLE, the block SHALL, on that edge:
  - set EDB <= CPU_DIN;
  - set PC <= START_PC;
  - clear the run counter and TIMEOUT;
  - go to RUN.
REQ-006 In RUN, ALU_EN SHALL be 1 every cycle; ALU_EN SHALL be 0 in IDLE.
REQ-007 In RUN, each cycle SHALL either increment PC or, if STOP_BIT=1, stop:
  - the stop instruction executes (ALU_EN=1 that cycle);
  - on the next edge the state goes to IDLE and PC holds.
REQ-008 PC SHALL wrap from 8'hFF to 8'h00 with no other effect.
REQ-009 The run counter SHALL increment each RUN cycle. If it reaches MAX_RUN without STOP_BIT, the block SHALL go to IDLE and set TIMEOUT=1.
REQ-010 MB_WR during RUN SHALL restart the run: same actions as REQ-005, state stays RUN, and the current cycle's STOP_BIT is ignored.
REQ-011 MB_RD_LO SHALL drive YLO=0 for exactly the following cycle; MB_RD_HI SHALL drive YHI=0 the same way.
REQ-012 At the end of the YLO/YHI-low cycle, the block SHALL:
  - set CPU_DOUT <= ALU_EDB;
  - pulse DOUT_VALID=1 for one cycle.
  Read-to-data latency SHALL be 2 cycles.
REQ-013 Simultaneous MB_RD_LO and MB_RD_HI SHALL assert YLO and YHI together and capture the full byte.
REQ-014 Reads SHALL be honoured in both IDLE and RUN; reads SHALL NOT alter state, PC, BUSY, or the run counter.
REQ-015 If MB_WR coincides with a read strobe, the write SHALL be accepted and the read dropped (no YLO/YHI, no DOUT_VALID).
REQ-016 YLO and YHI SHALL be registered outputs and glitch-free.

Reset
REQ-017 On RST, the block SHALL set:
  - state = IDLE; PC = 0; EDB = 0; run counter = 0;
  - CPU_DOUT = 0; DOUT_VALID = 0; BUSY = 0; TIMEOUT = 0;
  - ALU_EN = 0; YLO = 1; YHI = 1.
REQ-018 RST SHALL override every other input in the same cycle, including RST asserted mid-run and RST coincident with MB_WR.

Structure
REQ-019 The shared mathbox package SHALL hold the state enum, MAX_RUN default, and the widths of PC (8) and EDB (8).
REQ-020 Read-strobe generation and result capture SHALL be one sub-module, mathbox_rd_port; sequencing SHALL stay in mathbox_ctrl.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Write CPU_DIN=8'h5A, START_PC=8'h10, STOP_BIT=1 at PC 8'h13 -> EDB=8'h5A; PC steps 10,11,12,13; ALU_EN high 4 cycles; BUSY falls after 4 cycles; TIMEOUT=0.
  - START_PC=8'hFE, stop at 8'h01 -> PC sequence FE,FF,00,01; BUSY high 4 cycles.
  - STOP_BIT never set -> BUSY drops after 255 RUN cycles; TIMEOUT=1; the next MB_WR clears TIMEOUT.
  - Restart: MB_WR at PC=8'h12 with START_PC=8'h40 -> next PC=8'h40; EDB updated; BUSY stays high.
  - MB_RD_LO and MB_RD_HI together with ALU_EDB=8'hC3 -> YLO=YHI=0 one cycle; CPU_DOUT=8'hC3 with DOUT_VALID 2 cycles after the strobe; MB_RD_LO coincident with MB_WR -> no YLO pulse, no DOUT_VALID.
  - RST asserted mid-run -> all REQ-017 values on the next edge; BUSY=0.
